// File: rtl/mbit_warning_monitor.sv
// Multi-channel aging-warning event counter: synchronised inputs, level/edge event detect,
// saturating per-channel counters with sticky threshold alarms and a registered read-out mux.
`timescale 1ns/1ps
module mbit_warning_monitor #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned COUNT_W     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned SEL_W       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_CH-1:0]  warning_in,
  input  logic [NUM_CH-1:0]  clear,
  input  logic [COUNT_W-1:0] threshold,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [COUNT_W-1:0] rd_data,
  output logic [NUM_CH-1:0]  alarm,
  output logic               alarm_any,
  output logic [NUM_CH-1:0]  sat
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0]  sync;
  logic [NUM_CH-1:0]  ev;
  logic [COUNT_W-1:0] cnt_q [NUM_CH];
  logic [COUNT_W-1:0] rd_next;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync = warning_in;
    end else begin : g_sync
      logic [NUM_CH-1:0] stage_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            stage_q[s] <= '0;
          end
        end else begin
          stage_q[0] <= warning_in;
          for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            stage_q[s] <= stage_q[s-1];
          end
        end
      end

      assign sync = stage_q[SYNC_STAGES-1];
    end
  endgenerate

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic [NUM_CH-1:0] prev_q;

      // History tracks the synchronised input even while counting is disabled.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prev_q <= '0;
        end else begin
          prev_q <= sync;
        end
      end

      assign ev = sync & ~prev_q;
    end else begin : g_level
      assign ev = sync;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      alarm <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (clear[i]) begin
          cnt_q[i] <= '0;
          alarm[i] <= 1'b0;
        end else begin
          if (enable && ev[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_q[i] <= cnt_q[i] + COUNT_W'(1);
          end
          // Compares the pre-increment count, so the alarm trails the count by a cycle.
          if ((threshold != '0) && (cnt_q[i] >= threshold)) begin
            alarm[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    sat = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sat[i] = (cnt_q[i] == CNT_MAX);
    end
  end

  assign alarm_any = |alarm;

  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_next = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_mbit_warning_monitor.sv
// Bench for mbit_warning_monitor: a level-mode 4-channel and an edge-mode 3-channel instance
// checked every cycle against a delay-history behavioural model, plus directed literal checks.
`timescale 1ns/1ps
module tb_mbit_warning_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] warning_in = '0;
  logic [3:0] clear = '0;
  logic [3:0] threshold = '0;
  logic [1:0] rd_sel = '0;

  logic [3:0] rd_l, alarm_l, sat_l;
  logic       any_l;
  logic [3:0] rd_e;
  logic [2:0] alarm_e, sat_e;
  logic       any_e;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  mbit_warning_monitor #(.NUM_CH(4), .COUNT_W(4), .SYNC_STAGES(2), .EDGE_MODE(0), .SEL_W(2)) u_lvl (
    .clk(clk), .reset(reset), .enable(enable), .warning_in(warning_in), .clear(clear),
    .threshold(threshold), .rd_sel(rd_sel), .rd_data(rd_l), .alarm(alarm_l),
    .alarm_any(any_l), .sat(sat_l));

  mbit_warning_monitor #(.NUM_CH(3), .COUNT_W(4), .SYNC_STAGES(2), .EDGE_MODE(1), .SEL_W(2)) u_edge (
    .clk(clk), .reset(reset), .enable(enable), .warning_in(warning_in[2:0]), .clear(clear[2:0]),
    .threshold(threshold), .rd_sel(rd_sel), .rd_data(rd_e), .alarm(alarm_e),
    .alarm_any(any_e), .sat(sat_e));

  // Model: the counter sees the input sampled two edges earlier; an edge event is that
  // value high while the one sampled three edges earlier was low.
  logic [3:0] wh [3];
  int         m_cnt_l [4];
  int         m_cnt_e [3];
  logic [3:0] m_al_l;
  logic [2:0] m_al_e;
  int         m_rd_l, m_rd_e;

  always @(posedge clk or negedge reset) begin : model
    int         old_l [4];
    int         old_e [3];
    logic [3:0] s, sp;
    int         sel;
    if (!reset) begin
      for (int i = 0; i < 3; i++) wh[i] <= '0;
      for (int i = 0; i < 4; i++) m_cnt_l[i] <= 0;
      for (int i = 0; i < 3; i++) m_cnt_e[i] <= 0;
      m_al_l <= '0;
      m_al_e <= '0;
      m_rd_l <= 0;
      m_rd_e <= 0;
    end else begin
      s = wh[1];
      sp = wh[2];
      old_l = m_cnt_l;
      old_e = m_cnt_e;
      sel = int'(rd_sel);
      m_rd_l <= (sel < 4) ? old_l[sel] : 0;
      m_rd_e <= (sel < 3) ? old_e[sel] : 0;
      for (int i = 0; i < 4; i++) begin
        if (clear[i]) begin
          m_cnt_l[i] <= 0;
          m_al_l[i] <= 1'b0;
        end else begin
          if (enable && s[i] && old_l[i] < 15) m_cnt_l[i] <= old_l[i] + 1;
          if (threshold != 0 && old_l[i] >= int'(threshold)) m_al_l[i] <= 1'b1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (clear[i]) begin
          m_cnt_e[i] <= 0;
          m_al_e[i] <= 1'b0;
        end else begin
          if (enable && s[i] && !sp[i] && old_e[i] < 15) m_cnt_e[i] <= old_e[i] + 1;
          if (threshold != 0 && old_e[i] >= int'(threshold)) m_al_e[i] <= 1'b1;
        end
      end
      wh[2] <= wh[1];
      wh[1] <= wh[0];
      wh[0] <= warning_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  always @(negedge clk) begin : compare
    logic [3:0] es_l;
    logic [2:0] es_e;
    if (chk_en) begin
      for (int i = 0; i < 4; i++) es_l[i] = (m_cnt_l[i] == 15);
      for (int i = 0; i < 3; i++) es_e[i] = (m_cnt_e[i] == 15);
      check("lvl_rd_data", 32'(rd_l), 32'(m_rd_l));
      check("lvl_alarm", 32'(alarm_l), 32'(m_al_l));
      check("lvl_alarm_any", 32'(any_l), 32'(|m_al_l));
      check("lvl_sat", 32'(sat_l), 32'(es_l));
      check("edge_rd_data", 32'(rd_e), 32'(m_rd_e));
      check("edge_alarm", 32'(alarm_e), 32'(m_al_e));
      check("edge_alarm_any", 32'(any_e), 32'(|m_al_e));
      check("edge_sat", 32'(sat_e), 32'(es_e));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] w, input int n);
    warning_in = w;
    repeat (n) tick();
  endtask

  task automatic flush();
    warning_in = '0;
    repeat (4) tick();
  endtask

  task automatic clear_all();
    clear = 4'hF;
    tick();
    clear = '0;
  endtask

  // Literal expectations pin both the DUT and the model.
  task automatic read_chk(input int sel, input int exp_l, input int exp_e, input string name);
    rd_sel = 2'(sel);
    tick();
    check({name, "_lvl"}, 32'(rd_l), 32'(exp_l));
    check({name, "_edge"}, 32'(rd_e), 32'(exp_e));
    check({name, "_lvl_model"}, 32'(m_rd_l), 32'(exp_l));
    check({name, "_edge_model"}, 32'(m_rd_e), 32'(exp_e));
  endtask

  initial begin
    // Reset held with every warning high: everything must read zero.
    warning_in = 4'hF;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_rd_data", 32'(rd_l), 32'h0);
    check("rst_alarm", 32'(alarm_l), 32'h0);
    check("rst_alarm_any", 32'(any_l), 32'h0);
    check("rst_sat", 32'(sat_l), 32'h0);
    reset = 1'b1;

    // Four sampled-high edges after release: level +4, edge +1 per channel.
    hold(4'hF, 4);
    flush();
    for (int c = 0; c < 4; c++) read_chk(c, 4, (c < 3) ? 1 : 0, "post_reset");
    clear_all();

    // Level count of 7 with threshold 5 raises a sticky alarm on ch1 only.
    threshold = 4'd5;
    hold(4'b0010, 7);
    flush();
    read_chk(1, 7, 1, "lvl7");
    read_chk(0, 0, 0, "lvl7_other");
    check("lvl7_alarm", 32'(alarm_l), 32'b0010);
    check("lvl7_alarm_any", 32'(any_l), 32'h1);
    check("lvl7_edge_alarm", 32'(alarm_e), 32'h0);
    clear_all();

    // Saturation without wrap, then a single-channel clear.
    hold(4'b0100, 20);
    flush();
    read_chk(2, 15, 1, "sat");
    check("sat_flag", 32'(sat_l), 32'b0100);
    check("sat_alarm", 32'(alarm_l), 32'b0100);
    clear = 4'b0100;
    tick();
    clear = '0;
    flush();
    read_chk(2, 0, 0, "sat_cleared");
    check("sat_cleared_flag", 32'(sat_l), 32'h0);
    check("sat_cleared_alarm", 32'(alarm_l), 32'h0);

    // Square wave 3 high / 2 low x4, then 10 high: edge count 5, level saturates.
    for (int p = 0; p < 4; p++) begin
      hold(4'b0100, 3);
      hold(4'b0000, 2);
    end
    hold(4'b0100, 10);
    flush();
    read_chk(2, 15, 5, "edge_sq");
    clear_all();

    // Clear lands on the same edge as the single event it would have counted.
    warning_in = 4'b0001;
    tick();
    warning_in = 4'b0000;
    tick();
    clear = 4'b0001;
    tick();
    clear = '0;
    flush();
    read_chk(0, 0, 0, "clr_collide");

    // Disabled counting freezes everything.
    enable = 1'b0;
    hold(4'hF, 5);
    flush();
    enable = 1'b1;
    read_chk(1, 0, 0, "disabled");

    // Threshold 0 never alarms.
    threshold = 4'd0;
    hold(4'b0001, 8);
    flush();
    read_chk(0, 8, 1, "thr0");
    check("thr0_alarm", 32'(alarm_l), 32'h0);
    check("thr0_alarm_any", 32'(any_l), 32'h0);
    clear_all();

    // Randomised phase.
    for (int t = 0; t < 3000; t++) begin
      warning_in = 4'($urandom);
      clear = '0;
      for (int i = 0; i < 4; i++) clear[i] = ($urandom_range(0, 31) == 0);
      enable = ($urandom_range(0, 9) != 0);
      rd_sel = 2'($urandom);
      if (t % 50 == 0) threshold = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
